// File: rtl/jtcontra_snd_cmd.sv
// jtcontra_snd_cmd -- main-CPU side of the sound command link.
//
// Command bytes written by the main CPU are queued in a small FIFO. They are
// handed to the sound side one at a time: snd_latch is loaded, snd_irq is
// pulsed for IRQ_HOLD cycles, and then the block waits for snd_ack before the
// next byte is sent.
//
// Optional build macro: JTCONTRA_SNDCMD_TIMEOUT_EN. When it is defined, the
// wait for snd_ack gives up after TIMEOUT cycles and the next command is sent.
//
// Ports:
//   clk, rst         24 MHz clock, synchronous active-high reset
//   cpu_cen          main CPU clock enable; qualifies writes
//   cmd_cs, cmd_wr   chip select and write strobe from the main CPU decoder
//   cmd_din[7:0]     command byte
//   snd_ack          one-cycle pulse: the sound CPU has taken the command
//   snd_latch[7:0]   command byte presented to the sound subsystem
//   snd_irq          interrupt to the sound side (acts on the rising edge)
//   busy             FIFO not empty or a command is in flight
//   full             FIFO full
//   overflow         sticky: a write was dropped because the FIFO was full
//   level[AW:0]      FIFO occupancy
module jtcontra_snd_cmd #(
   parameter int          AW       = 2,
   parameter int          IRQ_HOLD = 8,
   parameter logic [15:0] TIMEOUT  = 16'd24000
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_cen,
   input  logic          cmd_cs,
   input  logic          cmd_wr,
   input  logic [7:0]    cmd_din,
   input  logic          snd_ack,
   output logic [7:0]    snd_latch,
   output logic          snd_irq,
   output logic          busy,
   output logic          full,
   output logic          overflow,
   output logic [AW:0]   level
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, LOAD, IRQ, WAIT_ACK} state_t;

   state_t          st;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]      hold_cnt;
   logic            ack_seen;
   logic            push_req, push, pop;

   assign push_req = cmd_cs & cmd_wr & cpu_cen;
   // LOAD is entered only with level!=0, so the pop is always valid.
   assign pop      = st == LOAD;
   assign full     = level == (AW+1)'(DEPTH);
   // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
   assign push     = push_req & (~full | pop);
   assign busy     = (level != '0) || (st != IDLE);

   // FIFO storage carries no reset; only the pointers and level define content.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push & ~pop)      level <= level + (AW+1)'(1);
         else if (pop & ~push) level <= level - (AW+1)'(1);
         if (push_req & ~push) overflow <= 1'b1;
      end
   end

`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
   logic [15:0] to_cnt;
`else
   logic [15:0] unused_timeout;
   assign unused_timeout = TIMEOUT;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         snd_latch <= 8'd0;
         snd_irq   <= 1'b0;
         hold_cnt  <= 8'd0;
         ack_seen  <= 1'b0;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
         to_cnt    <= 16'd0;
`endif
      end else begin
         case (st)
            IDLE: begin
               if (level != '0) st <= LOAD;
            end
            LOAD: begin
               snd_latch <= mem[rd_ptr];
               ack_seen  <= 1'b0;
               hold_cnt  <= 8'd0;
               snd_irq   <= 1'b1;
               st        <= IRQ;
            end
            IRQ: begin
               if (snd_ack) ack_seen <= 1'b1;
               if (hold_cnt == 8'(IRQ_HOLD-1)) begin
                  snd_irq <= 1'b0;
                  // an ack on the last hold cycle counts as early too
                  st      <= (ack_seen | snd_ack) ? IDLE : WAIT_ACK;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
                  to_cnt  <= 16'd0;
`endif
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            WAIT_ACK: begin
               if (snd_ack) st <= IDLE;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
               else if (to_cnt == TIMEOUT - 16'd1) st <= IDLE;
               else to_cnt <= to_cnt + 16'd1;
`endif
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Bench for jtcontra_snd_cmd. Expected command bytes go into a scoreboard
// queue when written; a monitor pops one on every rising edge of snd_irq and
// also checks pulse width and latch stability. Status outputs are checked at
// hand-computed cycles from the stimulus thread.
module tb_jtcontra_snd_cmd;

   localparam int AW       = 2;
   localparam int IRQ_HOLD = 8;

   logic       clk = 1'b0, rst = 1'b1;
   logic       cpu_cen = 1'b0, cmd_cs = 1'b0, cmd_wr = 1'b0, snd_ack = 1'b0;
   logic [7:0] cmd_din = 8'd0;
   logic [7:0] snd_latch;
   logic       snd_irq, busy, full, overflow;
   logic [AW:0] level;

   jtcontra_snd_cmd #(.AW(AW), .IRQ_HOLD(IRQ_HOLD), .TIMEOUT(16'd100)) dut (
      .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cmd_cs(cmd_cs), .cmd_wr(cmd_wr),
      .cmd_din(cmd_din), .snd_ack(snd_ack), .snd_latch(snd_latch),
      .snd_irq(snd_irq), .busy(busy), .full(full), .overflow(overflow),
      .level(level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   int         rise_cnt = 0, rise_cyc = 0, fall_cyc = 0, hi_cnt = 0;
   logic       prev_irq = 1'b0, aborted = 1'b0;
   logic [7:0] cap = 8'd0;

   always @(negedge clk) begin
      if (rst && (snd_irq || prev_irq)) aborted = 1'b1;
      if (snd_irq && !prev_irq) begin
         rise_cnt++;
         rise_cyc = cyc;
         cap      = snd_latch;
         hi_cnt   = 0;
         aborted  = 1'b0;
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL irq_edge: got command %0h, expected none (scoreboard empty)", snd_latch);
         end else begin
            check("latch_at_irq", snd_latch, exp_q.pop_front());
         end
      end
      if (snd_irq) hi_cnt++;
      if (!snd_irq && prev_irq) begin
         fall_cyc = cyc;
         if (!aborted) begin
            check("irq_width", hi_cnt, IRQ_HOLD);
            check("latch_stable", snd_latch, cap);
         end
      end
      prev_irq = snd_irq;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic tick_n(input int n);
      repeat (n) tick();
   endtask

   task automatic drive_wr(input logic [7:0] v);
      cmd_cs = 1'b1; cmd_wr = 1'b1; cpu_cen = 1'b1; cmd_din = v;
   endtask

   task automatic clear_wr();
      cmd_cs = 1'b0; cmd_wr = 1'b0; cpu_cen = 1'b0;
   endtask

   task automatic wait_rise(input int bound);
      int r0, k;
      r0 = rise_cnt; k = 0;
      while (rise_cnt == r0 && k < bound) begin tick(); k++; end
      if (rise_cnt == r0) begin
         n_cmp++; n_err++;
         $display("FAIL wait_rise: got no snd_irq rise in %0d cycles, expected one", bound);
      end
   endtask

   // wait for the current pulse to end, then acknowledge in WAIT_ACK
   task automatic ack_cur();
      int k;
      k = 0;
      while (snd_irq && k < 40) begin tick(); k++; end
      if (snd_irq) begin
         n_cmp++; n_err++;
         $display("FAIL wait_fall: got snd_irq=1 after 40 cycles, expected 0");
      end
      snd_ack = 1'b1; tick(); snd_ack = 1'b0;
   endtask

   // ---------------- directed test sequence ----------------
   initial begin
      int r0;
      // reset state
      tick_n(3);
      check("rst_latch", snd_latch, 8'h00);
      check("rst_irq", snd_irq, 0);
      check("rst_busy", busy, 0);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_level", level, 0);

      // single command, cycle 0 = write cycle
      rst = 1'b0; drive_wr(8'h5A); exp_q.push_back(8'h5A);
      tick(); clear_wr();                        // c1
      check("t1_level_c1", level, 1);
      check("t1_busy_c1", busy, 1);
      tick();                                    // c2 (LOAD)
      check("t1_irq_c2", snd_irq, 0);
      check("t1_latch_c2", snd_latch, 8'h00);
      tick();                                    // c3
      check("t1_latch_c3", snd_latch, 8'h5A);
      check("t1_irq_c3", snd_irq, 1);
      tick_n(7);                                 // c10
      check("t1_irq_c10", snd_irq, 1);
      tick();                                    // c11
      check("t1_irq_c11", snd_irq, 0);
      check("t1_busy_c11", busy, 1);
      tick_n(3); snd_ack = 1'b1;                 // c14
      tick(); snd_ack = 1'b0;                    // c15
      check("t1_busy_c15", busy, 0);
      check("t1_level_c15", level, 0);

      // early ack inside the IRQ window
      drive_wr(8'h11); exp_q.push_back(8'h11);   // c0
      tick(); clear_wr();                        // c1
      tick_n(4); snd_ack = 1'b1;                 // c5
      tick(); snd_ack = 1'b0;                    // c6
      tick_n(4);                                 // c10
      check("t2_irq_c10", snd_irq, 1);
      tick();                                    // c11
      check("t2_irq_c11", snd_irq, 0);
      check("t2_busy_c11", busy, 0);
      // write strobes without cpu_cen are ignored
      cmd_cs = 1'b1; cmd_wr = 1'b1; cpu_cen = 1'b0; cmd_din = 8'hEE;
      tick_n(2); clear_wr(); tick();
      check("t2_nocen_level", level, 0);
      check("t2_nocen_busy", busy, 0);

      // queue and overflow: 01..06 back to back, 06 is dropped
      for (int i = 0; i < 6; i++) begin
         drive_wr(8'(i + 1));
         if (i < 5) exp_q.push_back(8'(i + 1));
         tick();
         if (i == 4) begin                       // c5
            check("t3_level_c5", level, 4);
            check("t3_full_c5", full, 1);
            check("t3_ovf_c5", overflow, 0);
         end
      end
      clear_wr();                                // c6
      check("t3_level_c6", level, 4);
      check("t3_ovf_c6", overflow, 1);
      ack_cur();
      repeat (4) begin wait_rise(40); ack_cur(); end
      check("t3_busy_end", busy, 0);
      check("t3_sb_empty", exp_q.size(), 0);
      check("t3_ovf_sticky", overflow, 1);

      // reset in the middle of a pulse
      for (int i = 0; i < 3; i++) begin
         drive_wr(8'h77 + 8'(i));
         if (i == 0) exp_q.push_back(8'h77);
         tick();
      end
      clear_wr();                                // c3
      tick_n(5); rst = 1'b1;                     // c8
      check("t5_irq_c8", snd_irq, 1);
      tick(); rst = 1'b0; exp_q.delete();        // c9
      check("t5_irq", snd_irq, 0);
      check("t5_level", level, 0);
      check("t5_latch", snd_latch, 8'h00);
      check("t5_ovf", overflow, 0);
      check("t5_busy", busy, 0);
      r0 = rise_cnt;
      tick_n(20);
      check("t5_no_resume", rise_cnt, r0);

      // full FIFO with a push in the LOAD cycle
      drive_wr(8'hA0); exp_q.push_back(8'hA0);   // c0
      tick(); clear_wr();                        // c1
      tick_n(11);                                // c12, WAIT_ACK
      for (int i = 1; i <= 4; i++) begin
         drive_wr(8'hA0 + 8'(i)); exp_q.push_back(8'hA0 + 8'(i)); tick();
      end
      clear_wr();                                // c16
      check("t4_level_full", level, 4);
      check("t4_full", full, 1);
      snd_ack = 1'b1;
      tick(); snd_ack = 1'b0;                    // c17 IDLE
      tick();                                    // c18 LOAD
      drive_wr(8'hA5); exp_q.push_back(8'hA5);
      tick(); clear_wr();                        // c19
      check("t4_level_pp", level, 4);
      check("t4_full_pp", full, 1);
      check("t4_ovf_pp", overflow, 0);
      ack_cur();
      repeat (4) begin wait_rise(40); ack_cur(); end
      check("t4_busy_end", busy, 0);
      check("t4_sb_empty", exp_q.size(), 0);

      // two queued commands, never acknowledged
      drive_wr(8'hB0); exp_q.push_back(8'hB0); tick();
      drive_wr(8'hB1); exp_q.push_back(8'hB1); tick();
      clear_wr();
      wait_rise(20);
      while (snd_irq) tick();
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
      wait_rise(200);
      check("t6_timeout_gap", rise_cyc - fall_cyc, 102);
      tick_n(250);
      check("t6_busy_end", busy, 0);
      check("t6_sb_empty", exp_q.size(), 0);
`else
      r0 = rise_cnt;
      tick_n(10000);
      check("t6_no_second_rise", rise_cnt, r0);
      check("t6_still_busy", busy, 1);
      rst = 1'b1; tick(); rst = 1'b0; exp_q.delete(); tick();
      check("t6_busy_after_rst", busy, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
